// File: rtl/minute_counter.sv
// minute_counter: seconds/minutes stage of the clock chain.
//   Counts seconds from a 1 Hz strobe, keeps minutes 0-59 and emits a
//   one-cycle carry to the hour stage on the 59:59 -> 00:00 wrap. In set mode
//   the add/deduct buttons adjust minutes and seconds are held at 0.
// Ports:
//   clk      - system clock, rising edge
//   rst      - synchronous active-high reset
//   tick_1hz - one-cycle strobe per second, synchronous to clk
//   mode     - async switch, 0 = run, 1 = set
//   add      - async active-low button, increments minutes in set mode
//   deduct   - async active-low button, decrements minutes in set mode
//   minute   - registered one-cycle carry to the hour stage
//   sec      - seconds 0-59
//   min      - minutes 0-59
//   seg      - minute display, [6:0] ones digit, [13:7] tens digit

// minute_counter_debounce: 2-flop synchronizer, debouncer and press detector
// for one active-low button.
//   clk, rst  - as in the top module
//   btn_async - raw active-low button
//   press     - one-cycle pulse on each accepted 1 -> 0 transition
module minute_counter_debounce #(
    parameter int unsigned CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_async,
    output logic press
);
    localparam int unsigned CNT_W = $clog2(CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = btn_async;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        // Level flips only after CYCLES consecutive samples differing from it;
        // any sample equal to the stable level restarts the window.
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = stable_q & ~stable_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    assign press = press_q;
endmodule

// bin_to_bcd4: binary 0-63 to two 4-bit BCD digits (shift-and-add-3).
//   bin  - binary value
//   tens - tens digit
//   ones - ones digit
module bin_to_bcd4 (
    input  logic [5:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones
);
    logic [13:0] shift;

    always_comb begin
        shift      = '0;
        shift[5:0] = bin;
        for (int unsigned i = 0; i < 6; i++) begin
            for (int unsigned d = 0; d < 2; d++) begin
                if (shift[6 + 4*d +: 4] >= 4'd5) begin
                    shift[6 + 4*d +: 4] = shift[6 + 4*d +: 4] + 4'd3;
                end
            end
            shift = shift << 1;
        end
        ones = shift[9:6];
        tens = shift[13:10];
    end
endmodule

// led7_decoder: BCD digit to active-high segments {g,f,e,d,c,b,a}.
//   digit - BCD digit, values above 9 blank the display
//   seg   - segment drive
module led7_decoder (
    input  logic [3:0] digit,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'h00;
        case (digit)
            4'd0: seg = 7'h3F;
            4'd1: seg = 7'h06;
            4'd2: seg = 7'h5B;
            4'd3: seg = 7'h4F;
            4'd4: seg = 7'h66;
            4'd5: seg = 7'h6D;
            4'd6: seg = 7'h7D;
            4'd7: seg = 7'h07;
            4'd8: seg = 7'h7F;
            4'd9: seg = 7'h6F;
            default: seg = 7'h00;
        endcase
    end
endmodule

module minute_counter #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1hz,
    input  logic        mode,
    input  logic        add,
    input  logic        deduct,
    output logic        minute,
    output logic [5:0]  sec,
    output logic [5:0]  min,
    output logic [13:0] seg
);
    logic       mode_s1_q, mode_s1_d;
    logic       mode_s2_q, mode_s2_d;
    logic [5:0] sec_q, sec_d;
    logic [5:0] min_q, min_d;
    logic       minute_q, minute_d;
    logic       add_press, deduct_press;
    logic [3:0] tens, ones;

    minute_counter_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_add_db (
        .clk       (clk),
        .rst       (rst),
        .btn_async (add),
        .press     (add_press)
    );

    minute_counter_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deduct_db (
        .clk       (clk),
        .rst       (rst),
        .btn_async (deduct),
        .press     (deduct_press)
    );

    always_comb begin
        mode_s1_d = mode;
        mode_s2_d = mode_s1_q;
        sec_d     = sec_q;
        min_d     = min_q;
        minute_d  = 1'b0;
        if (mode_s2_q) begin
            sec_d = '0;
            // Simultaneous add and deduct cancel out.
            if (add_press && !deduct_press) begin
                min_d = (min_q >= 6'd59) ? 6'd0 : min_q + 6'd1;
            end else if (deduct_press && !add_press) begin
                min_d = (min_q == 6'd0 || min_q > 6'd59) ? 6'd59 : min_q - 6'd1;
            end
        end else if (tick_1hz) begin
            if (sec_q >= 6'd59) begin
                sec_d = '0;
                if (min_q >= 6'd59) begin
                    min_d    = '0;
                    minute_d = 1'b1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_s1_q <= 1'b1;
            mode_s2_q <= 1'b1;
            sec_q     <= '0;
            min_q     <= '0;
            minute_q  <= 1'b0;
        end else begin
            mode_s1_q <= mode_s1_d;
            mode_s2_q <= mode_s2_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            minute_q  <= minute_d;
        end
    end

    bin_to_bcd4 u_bcd (
        .bin  (min_q),
        .tens (tens),
        .ones (ones)
    );

    led7_decoder u_ones (
        .digit (ones),
        .seg   (seg[6:0])
    );

    led7_decoder u_tens (
        .digit (tens),
        .seg   (seg[13:7])
    );

    assign minute = minute_q;
    assign sec    = sec_q;
    assign min    = min_q;
endmodule

// File: tb/tb_minute_counter.sv
// Directed bench for minute_counter with a small debounce window. Expected
// values come from a bench-side clock model and go through a scoreboard queue.
module tb_minute_counter;
    localparam int unsigned DB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick_1hz;
    logic        mode;
    logic        add;
    logic        deduct;
    logic        minute;
    logic [5:0]  sec;
    logic [5:0]  min;
    logic [13:0] seg;

    always #5 clk = ~clk;

    minute_counter #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_1hz (tick_1hz),
        .mode     (mode),
        .add      (add),
        .deduct   (deduct),
        .minute   (minute),
        .sec      (sec),
        .min      (min),
        .seg      (seg)
    );

    typedef struct {
        string       tag;
        logic [13:0] val;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   m_sec = 0;
    int   m_min = 0;
    int   pulse_cnt = 0;
    int   base;

    always @(negedge clk) begin
        if (minute === 1'b1) pulse_cnt++;
    end

    function automatic logic [6:0] seg7(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            9: return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [13:0] seg_of(input int v);
        return {seg7(v / 10), seg7(v % 10)};
    endfunction

    task automatic push(input string tag, input logic [13:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [13:0] obs);
        exp_t e;
        tests++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL sb_empty observed=%0d expected=<entry>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                fails++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_state(input string tag, input bit carry);
        push({tag, "_sec"}, 14'(m_sec));
        push({tag, "_min"}, 14'(m_min));
        push({tag, "_minute"}, 14'(carry));
        push({tag, "_seg"}, seg_of(m_min));
    endtask

    task automatic check_state();
        check(14'(sec));
        check(14'(min));
        check(14'(minute));
        check(seg);
    endtask

    // Advances the model for one strobe; returns the expected carry.
    task automatic model_tick(input bit run, output bit carry);
        carry = 1'b0;
        if (!run) begin
            m_sec = 0;
        end else if (m_sec == 59) begin
            m_sec = 0;
            if (m_min == 59) begin
                m_min = 0;
                carry = 1'b1;
            end else begin
                m_min++;
            end
        end else begin
            m_sec++;
        end
    endtask

    task automatic do_tick(input bit run, input string tag);
        bit carry;
        model_tick(run, carry);
        push_state(tag, carry);
        tick_1hz = 1'b1;
        cyc(1);
        tick_1hz = 1'b0;
        check_state();
    endtask

    task automatic fast_tick();
        bit carry;
        model_tick(1'b1, carry);
        tick_1hz = 1'b1;
        cyc(1);
        tick_1hz = 1'b0;
    endtask

    task automatic press(input bit is_add, input bit is_ded, input string tag);
        if (is_add && !is_ded) m_min = (m_min == 59) ? 0 : m_min + 1;
        if (is_ded && !is_add) m_min = (m_min == 0) ? 59 : m_min - 1;
        push({tag, "_held_min"}, 14'(m_min));
        push({tag, "_rel_min"}, 14'(m_min));
        push({tag, "_rel_seg"}, seg_of(m_min));
        push({tag, "_rel_sec"}, 14'(0));
        add    = ~is_add;
        deduct = ~is_ded;
        cyc(DB + 6);
        check(14'(min));
        add    = 1'b1;
        deduct = 1'b1;
        cyc(DB + 6);
        check(14'(min));
        check(seg);
        check(14'(sec));
    endtask

    initial begin
        rst      = 1'b1;
        tick_1hz = 1'b0;
        mode     = 1'b0;
        add      = 1'b1;
        deduct   = 1'b1;
        cyc(3);
        push_state("reset", 1'b0);
        check_state();
        rst = 1'b0;
        cyc(3);

        // Run mode: one full minute of ticks.
        for (int i = 0; i < 60; i++) do_tick(1'b1, "run_tick");
        push("run_no_carry", 14'(0));
        check(14'(pulse_cnt));

        // Preload to 59:58 via set mode then run.
        mode = 1'b1;
        cyc(3);
        press(1'b0, 1'b1, "pre_ded0");
        press(1'b0, 1'b1, "pre_ded1");
        mode = 1'b0;
        cyc(3);
        for (int i = 0; i < 58; i++) fast_tick();
        base = pulse_cnt;
        do_tick(1'b1, "wrap_59");
        do_tick(1'b1, "wrap_00");
        push("carry_drop", 14'(0));
        cyc(1);
        check(14'(minute));
        push("carry_count", 14'(1));
        check(14'(pulse_cnt - base));

        // Set mode adjustments with wrap in both directions.
        mode = 1'b1;
        cyc(3);
        base = pulse_cnt;
        press(1'b0, 1'b1, "set_ded_wrap");
        press(1'b0, 1'b1, "set_ded58");
        press(1'b1, 1'b0, "set_add59");
        press(1'b1, 1'b0, "set_add_wrap");
        press(1'b1, 1'b0, "set_add1");
        press(1'b0, 1'b1, "set_ded0");
        press(1'b0, 1'b1, "set_ded_wrap2");

        // Bouncing add: short lows, then a held press, then a bouncy release.
        m_min = (m_min == 59) ? 0 : m_min + 1;
        push("bounce_press_min", 14'(m_min));
        push("bounce_release_min", 14'(m_min));
        for (int k = 0; k < 7; k++) begin
            add = 1'b0;
            cyc(2);
            add = 1'b1;
            cyc(1);
        end
        add = 1'b0;
        cyc(12);
        check(14'(min));
        for (int k = 0; k < 7; k++) begin
            add = 1'b1;
            cyc(2);
            add = 1'b0;
            cyc(1);
        end
        add = 1'b1;
        cyc(12);
        check(14'(min));

        press(1'b1, 1'b1, "both");
        for (int i = 0; i < 5; i++) do_tick(1'b0, "set_tick");
        push("set_no_carry", 14'(0));
        check(14'(pulse_cnt - base));

        // Run to 37:12, then reset with a press pending.
        mode = 1'b0;
        cyc(3);
        m_sec = 0;
        for (int i = 0; i < 37 * 60 + 11; i++) fast_tick();
        do_tick(1'b1, "pre_rst");
        mode = 1'b1;
        add  = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(1);
        m_sec = 0;
        m_min = 0;
        push_state("mid_rst", 1'b0);
        check_state();
        add = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(DB + 8);
        push_state("post_rst", 1'b0);
        check_state();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/minute_counter.md
# minute_counter

Upstream stage of the clock chain. Counts seconds from a 1 Hz strobe, keeps minutes 0–59 and emits a one-cycle minute carry that drives the `minute` input of the hour stage. Drives its own two-digit minute display. Has the same run/set mode and add/deduct buttons as the hour stage, so both stages are adjusted from one shared control panel.

## Interface
- `DEBOUNCE_CYCLES`, 250000: clk cycles a button must stay stable before a level change is accepted (5 ms at 50 MHz).
- `clk` in 1: system clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `tick_1hz` in 1: one-clk-wide strobe, once per second, synchronous to `clk`.
- `mode` in 1: 0 = run, 1 = set; asynchronous switch.
- `add` in 1: active-low push button; asynchronous; increments minutes in set mode.
- `deduct` in 1: active-low push button; asynchronous; decrements minutes in set mode.
- `minute` out 1: carry to the hour stage; one-clk pulse on 59→0 wrap in run mode.
- `sec` out 6: current seconds, 0–59.
- `min` out 6: current minutes, 0–59.
- `seg` out 14: minute display; `[6:0]` ones digit, `[13:7]` tens digit. Produced by `bin_to_bcd4` followed by two `led7_decoder` instances.

## Operation
- Input conditioning:
  - `mode`, `add` and `deduct` each pass through a 2-flop synchronizer.
  - `add` and `deduct` are then debounced. The stable level updates only after the synchronized input differs from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - A press event is a 1→0 transition of the debounced level: one cycle per physical press. A release generates nothing.
- Run mode (synced mode = 0):
  - On `tick_1hz`, `sec` increments.
  - At `sec` = 59, a tick sets `sec` to 0 and increments `min`.
  - At `min` = 59 with `sec` = 59, a tick sets both to 0 and asserts `minute` for exactly one cycle.
  - Press events are ignored.
- Set mode (synced mode = 1):
  - `sec` is forced to 0 and held; `tick_1hz` is ignored.
  - Add press: `min` increments; 59 wraps to 0.
  - Deduct press: `min` decrements; 0 wraps to 59.
  - No `minute` pulse is generated in set mode, including on wrap; the hour stage is set independently.
  - Add and deduct press events in the same cycle: both ignored.
- Mode 1→0: counting resumes from `sec` = 0 with the current `min`.
- Mode 0→1 on the same cycle as a carry tick: the tick is lost; no carry is emitted.
- Width rules:
  - `sec` and `min` never hold a value above 59.
  - The debounce counter width is `$clog2(DEBOUNCE_CYCLES+1)`.

## Timing
- Reset, `rst` high at a rising edge:
  - `sec` = 0, `min` = 0, `minute` = 0, and `seg` shows "00".
  - Synchronizers and debounced levels go to 1 (released); debounce counters go to 0.
  - `rst` overrides every other input. Reset during a debounce window discards the pending press.
- Tick latency: `tick_1hz` high at edge N → `sec` and `min` updated at edge N+1.
- Carry: `minute` is registered. It is high for the cycle after edge N+1, in the same cycle that `min` first reads 0, and low again at edge N+2.
- Button latency: an input low from edge N gives a press event at edge N + 2 + `DEBOUNCE_CYCLES` (±1 cycle); `min` changes one edge later.
- Mode latency: a `mode` change takes effect 2 edges after it is sampled.
- `seg` is combinational from `min`.

## Test plan
- Reset, then 60 ticks with `mode` = 0 → `sec` steps 0..59 then 0; `min` = 1 after tick 60; `minute` stays low.
- Preload to `min` = 59, `sec` = 58 (set mode plus ticks), then 2 ticks in run mode → `min` = 0 and `sec` = 0; `minute` high for exactly 1 cycle, coincident with `min` = 0.
- With `DEBOUNCE_CYCLES` = 4 in set mode:
  - 3 add presses from 58 → `min` = 59, 0, 1.
  - Deduct press at `min` = 0 → `min` = 59.
  - `minute` never pulses.
- Bounce on `add`: glitches shorter than 4 cycles for 20 cycles, then a held low → exactly one increment; release bounce causes no change.
- Add and deduct pressed together → `min` unchanged. Ticks during set mode → `sec` stays 0.
- Assert `rst` mid-count (`min` = 37, `sec` = 12) and during a pending press → all outputs 0, `seg` shows "00", no increment after release of `rst`.
